// File: rtl/cic_decim_ctrl.sv
// CIC decimator control: sequences integrator/comb resets, gates input
// samples into the integrator chain, counts samples modulo R and times the
// comb enable / output valid pulses to line up with the datapath latency.
module cic_decim_ctrl #(
    parameter int DIN_WIDTH  = 16,
    parameter int STAGES     = 3,
    parameter int RATE_WIDTH = 16
) (
    input  logic                        clk_in,
    input  logic                        rst,
    input  logic signed [DIN_WIDTH-1:0] din,
    input  logic                        din_valid,
    input  logic [RATE_WIDTH-1:0]       cfg_rate,
    input  logic                        cfg_load,
    input  logic                        cfg_start,
    input  logic                        cfg_stop,
    output logic signed [DIN_WIDTH-1:0] din_int,
    output logic                        int_rst,
    output logic                        comb_rst,
    output logic                        comb_en,
    output logic                        dout_valid,
    output logic                        cfg_err,
    output logic                        busy,
    output logic [1:0]                  state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Tick pipeline: bit k is set k edges after the edge that accepted the
    // tick sample. comb_en taps bit STAGES+1, dout_valid taps bit 2*STAGES+1.
    localparam int PIPE_LEN = 2 * STAGES + 2;
    localparam int PH_W     = (2 * STAGES > 1) ? $clog2(2 * STAGES) : 1;

    state_t                         state_q, state_d;
    logic [RATE_WIDTH-1:0]          rate_q, rate_d;
    logic [RATE_WIDTH-1:0]          cnt_q, cnt_d;
    logic [PH_W-1:0]                phase_q, phase_d;
    logic [PIPE_LEN-1:0]            pipe_q, pipe_d;
    logic signed [DIN_WIDTH-1:0]    din_int_q, din_int_d;
    logic                           int_rst_q, int_rst_d;
    logic                           comb_rst_q, comb_rst_d;
    logic                           cfg_err_q, cfg_err_d;
    logic                           busy_q, busy_d;

    logic accept;
    logic load_ok;
    logic load_bad;
    logic abort;

    // Next-state logic: strobe arbitration, sample counting, tick timing
    always_comb begin
        state_d   = state_q;
        rate_d    = rate_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        pipe_d    = {pipe_q[PIPE_LEN-2:0], 1'b0};
        cfg_err_d = 1'b0;
        abort     = 1'b0;

        accept   = (state_q == ST_RUN) && din_valid;
        load_ok  = cfg_load && (cfg_rate >= RATE_WIDTH'(2));
        load_bad = cfg_load && !load_ok;

        // Idle cycles feed zeros so the free-running integrators hold value
        din_int_d = accept ? din : '0;

        // Sample counter modulo R; the R-th sample launches a tick
        if (accept) begin
            if (cnt_q == rate_q - RATE_WIDTH'(1)) begin
                cnt_d     = '0;
                pipe_d[0] = 1'b1;
            end else begin
                cnt_d = cnt_q + RATE_WIDTH'(1);
            end
        end

        if (load_bad) begin
            cfg_err_d = 1'b1;
        end
        if (load_ok) begin
            rate_d = cfg_rate;
        end

        unique case (state_q)
            ST_IDLE: begin
                // Any load on the same cycle outranks start
                if (cfg_start && !cfg_load) begin
                    state_d = ST_FLUSH;
                    phase_d = '0;
                end
            end
            ST_FLUSH: begin
                if (phase_q == PH_W'(STAGES)) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_RUN: begin
                if (load_ok) begin
                    abort = 1'b1;
                end else if (cfg_stop && !cfg_load) begin
                    state_d = ST_DRAIN;
                    phase_d = '0;
                end
            end
            ST_DRAIN: begin
                if (load_ok) begin
                    abort = 1'b1;
                end else if (phase_q == PH_W'(2 * STAGES - 1)) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new rate mid-stream discards all in-flight work and re-flushes
        if (abort) begin
            state_d = ST_FLUSH;
            phase_d = '0;
            pipe_d  = '0;
        end

        // Partial counts never survive leaving RUN
        if (state_d != ST_RUN) begin
            cnt_d = '0;
        end

        int_rst_d  = (state_d == ST_IDLE) || (state_d == ST_FLUSH);
        comb_rst_d = (state_d == ST_IDLE) || (state_d == ST_FLUSH);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and registered outputs, cleared asynchronously by rst
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rate_q     <= RATE_WIDTH'(2);
            cnt_q      <= '0;
            phase_q    <= '0;
            pipe_q     <= '0;
            din_int_q  <= '0;
            int_rst_q  <= 1'b1;
            comb_rst_q <= 1'b1;
            cfg_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rate_q     <= rate_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            pipe_q     <= pipe_d;
            din_int_q  <= din_int_d;
            int_rst_q  <= int_rst_d;
            comb_rst_q <= comb_rst_d;
            cfg_err_q  <= cfg_err_d;
            busy_q     <= busy_d;
        end
    end

    assign din_int    = din_int_q;
    assign int_rst    = int_rst_q;
    assign comb_rst   = comb_rst_q;
    assign comb_en    = pipe_q[STAGES+1];
    assign dout_valid = pipe_q[2*STAGES+1];
    assign cfg_err    = cfg_err_q;
    assign busy       = busy_q;
    assign state      = state_q;

endmodule
